mem_ldst_tracker: RTL

- Non-blocking successor to the single-outstanding MEM-stage load/store handshake.
- Tracks up to DEPTH in-order outstanding data-memory requests issued by EXE.
- Captures each in-order data_ok response into its own entry, then aligns and sign/zero-extends load data.
- Presents completed accesses to WB through a valid/ready handshake.
- Silently discards responses of requests cancelled by an exception, ertn or refetch flush.

---
 rtl/mem_ldst_tracker_pkg.sv | 29 ++
 rtl/mem_ldst_tracker_ld_extract.sv | 59 +++++
 rtl/mem_ldst_tracker.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_ldst_tracker_pkg.sv
// Shared types for the MEM-stage load/store tracker: access size codes,
// the per-entry control record and the pointer-width helper.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Offset is kept at the width needed by a 64-bit bus so the record is bus-width agnostic.
    localparam int OFF_MAX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic                 filled;
        logic                 cancelled;
        logic                 is_load;
        logic [1:0]           size;
        logic                 sgn;
        logic [OFF_MAX_W-1:0] offset;
    } entry_t;

    localparam entry_t ENTRY_NULL = '0;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mem_ldst_tracker_ld_extract.sv
// Load-data alignment: shift the bus word down by the byte offset, mask to the
// access size and sign/zero-extend. Stores yield zero.
module ld_extract
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]    i_data,
    input  logic [1:0]           i_size,
    input  logic                 i_signed,
    input  logic [OFF_MAX_W-1:0] i_offset,
    input  logic                 i_is_load,
    output logic [DATA_W-1:0]    o_result
);

    localparam logic [63:0] M_B = 64'h0000_0000_0000_00FF;
    localparam logic [63:0] M_H = 64'h0000_0000_0000_FFFF;
    localparam logic [63:0] M_W = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] M_D = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_mask;
    logic              w_sbit;

    assign w_shifted = i_data >> {i_offset, 3'b000};

    // Size-dependent mask and sign-bit selection.
    always_comb begin
        w_mask = {DATA_W{1'b0}};
        w_sbit = 1'b0;
        case (i_size)
            SZ_B: begin
                w_mask = M_B[DATA_W-1:0];
                w_sbit = w_shifted[7];
            end
            SZ_H: begin
                w_mask = M_H[DATA_W-1:0];
                w_sbit = w_shifted[15];
            end
            SZ_W: begin
                w_mask = M_W[DATA_W-1:0];
                w_sbit = w_shifted[31];
            end
            SZ_D: begin
                w_mask = M_D[DATA_W-1:0];
                w_sbit = w_shifted[DATA_W-1];
            end
            default: begin
                w_mask = {DATA_W{1'b0}};
                w_sbit = 1'b0;
            end
        endcase
    end

    assign o_result = i_is_load ?
        ((w_shifted & w_mask) | ({DATA_W{i_signed & w_sbit}} & ~w_mask)) :
        {DATA_W{1'b0}};

endmodule

// File: rtl/mem_ldst_tracker.sv
// Non-blocking MEM-stage tracker for up to DEPTH in-order data-memory requests.
// Define MEM_RESP_BYPASS_EN to forward a head response to WB in its data_ok cycle.
module mem_ldst_tracker
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int DEST_W = 5
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_is_load,
    input  logic [1:0]                    req_size,
    input  logic                          req_signed,
    input  logic [$clog2(DATA_W/8)-1:0]   req_offset,
    input  logic [DEST_W-1:0]             req_dest,
    input  logic                          data_ok,
    input  logic [DATA_W-1:0]             rdata,
    input  logic                          flush,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [DATA_W-1:0]             resp_data,
    output logic [DEST_W-1:0]             resp_dest,
    output logic                          resp_is_load,
    output logic [$clog2(DEPTH):0]        outstanding,
    output logic                          full,
    output logic                          empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int IW = PW - 1;

    entry_t            r_ent  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEST_W-1:0] r_dest [DEPTH];
    logic [PW-1:0]     r_tail;
    logic [PW-1:0]     r_fill;
    logic [PW-1:0]     r_head;

    logic [PW-1:0]     w_count;
    logic [IW-1:0]     w_tail_idx;
    logic [IW-1:0]     w_fill_idx;
    logic [IW-1:0]     w_head_idx;
    entry_t            w_head;
    logic              w_full;
    logic              w_ready;
    logic              w_alloc;
    logic              w_fill;
    logic              w_drop;
    logic              w_norm_valid;
    logic              w_byp;
    logic              w_byp_pop;
    logic              w_resp_valid;
    logic              w_pop;
    logic [DATA_W-1:0] w_src_data;
    logic [DATA_W-1:0] w_ext;

    assign w_tail_idx = r_tail[IW-1:0];
    assign w_fill_idx = r_fill[IW-1:0];
    assign w_head_idx = r_head[IW-1:0];
    assign w_head     = r_ent[w_head_idx];

    assign w_count = r_tail - r_head;
    assign w_full  = (w_count == PW'(DEPTH));
    assign w_ready = ~w_full & ~flush;
    assign w_alloc = req_valid & w_ready;
    // A response with nothing awaiting data is a protocol error and is dropped.
    assign w_fill  = data_ok & (r_fill != r_tail);

    assign w_drop       = w_head.valid & w_head.filled & w_head.cancelled;
    assign w_norm_valid = w_head.valid & w_head.filled & ~w_head.cancelled & ~flush;

`ifdef MEM_RESP_BYPASS_EN
    // An unfilled live head is always the fill target, so data_ok here belongs to it.
    assign w_byp = w_head.valid & ~w_head.filled & ~w_head.cancelled & data_ok & ~flush;
`else
    assign w_byp = 1'b0;
`endif

    assign w_resp_valid = w_norm_valid | w_byp;
    assign w_byp_pop    = w_byp & resp_ready;
    assign w_pop        = (w_resp_valid & resp_ready) | w_drop;
    assign w_src_data   = w_byp ? rdata : r_data[w_head_idx];

    ld_extract #(
        .DATA_W (DATA_W)
    ) u_extract (
        .i_data    (w_src_data),
        .i_size    (w_head.size),
        .i_signed  (w_head.sgn),
        .i_offset  (w_head.offset),
        .i_is_load (w_head.is_load),
        .o_result  (w_ext)
    );

    assign req_ready    = w_ready;
    assign resp_valid   = w_resp_valid;
    assign resp_data    = w_head.valid ? w_ext : {DATA_W{1'b0}};
    assign resp_dest    = w_head.valid ? r_dest[w_head_idx] : {DEST_W{1'b0}};
    assign resp_is_load = w_head.valid & w_head.is_load;
    assign outstanding  = w_count;
    assign full         = w_full;
    assign empty        = (w_count == {PW{1'b0}});

    // Entry and pointer update: fill, flush-cancel, pop and allocate can all coincide.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tail <= {PW{1'b0}};
            r_fill <= {PW{1'b0}};
            r_head <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i]  <= ENTRY_NULL;
                r_data[i] <= {DATA_W{1'b0}};
                r_dest[i] <= {DEST_W{1'b0}};
            end
        end else begin
            if (w_fill) begin
                r_fill <= r_fill + PW'(1);
                if (!w_byp_pop) begin
                    r_ent[w_fill_idx].filled <= 1'b1;
                    r_data[w_fill_idx]       <= rdata;
                end
            end
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_ent[i].valid) begin
                        r_ent[i].cancelled <= 1'b1;
                    end
                end
            end
            if (w_pop) begin
                r_ent[w_head_idx].valid <= 1'b0;
                r_head                  <= r_head + PW'(1);
            end
            if (w_alloc) begin
                r_ent[w_tail_idx] <= '{valid: 1'b1, filled: 1'b0, cancelled: 1'b0,
                                       is_load: req_is_load, size: req_size,
                                       sgn: req_signed, offset: OFF_MAX_W'(req_offset)};
                r_dest[w_tail_idx] <= req_dest;
                r_tail             <= r_tail + PW'(1);
            end
        end
    end

endmodule
